// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register file slice.
package regfile_pkg;
  localparam int unsigned RF_DATA_W   = 32;
  localparam int unsigned RF_NUM_REGS = 32;
  localparam int unsigned RF_ADDR_W   = 5;
  localparam int unsigned RF_ZERO_REG = 0;

  typedef logic [RF_ADDR_W-1:0] reg_addr_t;
  typedef logic [RF_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set/clear at the edge,
// two combinational lookups. Register 0 and out-of-range entries never set.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter int unsigned ADDR_W   = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_set_en,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic [ADDR_W-1:0] i_look_a,
  input  logic [ADDR_W-1:0] i_look_b,
  output logic              o_busy_a,
  output logic              o_busy_b
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] r_busy;

  // Entries outside 1..NUM_REGS-1 are only ever reset, so they read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      for (int unsigned i = RF_ZERO_REG + 1; i < NUM_REGS && i < DEPTH; i++) begin
        if (i_set_en && i_set_addr == ADDR_W'(i))
          r_busy[i] <= 1'b1;
        else if (i_clr_en && i_clr_addr == ADDR_W'(i))
          r_busy[i] <= 1'b0;
      end
    end
  end

  assign o_busy_a = r_busy[i_look_a];
  assign o_busy_b = r_busy[i_look_b];
endmodule

// File: rtl/register_file.sv
// Two-read/one-write register file with registered reads and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-edge write data to the read ports.
module register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter int unsigned ADDR_W   = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic              rd_we,
  input  logic [DATA_W-1:0] i_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DATA_W-1:0] out_data_a,
  output logic [DATA_W-1:0] out_data_b,
  output logic              busy_a,
  output logic              busy_b
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DATA_W-1:0] r_out_a;
  logic [DATA_W-1:0] r_out_b;
  logic              w_wr_valid;
  logic              w_byp_a;
  logic              w_byp_b;

  assign w_wr_valid = rd_we && (rd != ADDR_W'(RF_ZERO_REG)) && (32'(rd) < NUM_REGS);

`ifdef REGFILE_BYPASS_EN
  assign w_byp_a = w_wr_valid && (rd == rs);
  assign w_byp_b = w_wr_valid && (rd == rt);
`else
  assign w_byp_a = 1'b0;
  assign w_byp_b = 1'b0;
`endif

  // Storage is sized to the full address space; unwritable entries stay at
  // their reset value, which gives zero reads for r0 and out-of-range addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      for (int unsigned i = RF_ZERO_REG + 1; i < NUM_REGS && i < DEPTH; i++) begin
        if (w_wr_valid && rd == ADDR_W'(i)) r_regs[i] <= i_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_a <= '0;
      r_out_b <= '0;
    end else begin
      r_out_a <= w_byp_a ? i_data : r_regs[rs];
      r_out_b <= w_byp_b ? i_data : r_regs[rt];
    end
  end

  assign out_data_a = r_out_a;
  assign out_data_b = r_out_b;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set_en   (rsv_en),
    .i_set_addr (rsv_addr),
    .i_clr_en   (rd_we),
    .i_clr_addr (rd),
    .i_look_a   (rs),
    .i_look_b   (rt),
    .o_busy_a   (busy_a),
    .o_busy_b   (busy_b)
  );
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a 32-entry instance checked against a
// behavioural model through an expected-read queue, plus a 16-entry instance.
module tb_register_file;
  import regfile_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  reg_addr_t   rs, rt, rd, rsv_addr;
  logic        rd_we, rsv_en;
  reg_data_t   i_data;
  reg_data_t   out_a, out_b;
  logic        busy_a, busy_b;

  reg_addr_t   s_rs, s_rt, s_rd, s_rsv_addr;
  logic        s_we, s_rsv_en;
  reg_data_t   s_data, s_out_a, s_out_b;
  logic        s_busy_a, s_busy_b;

  register_file #(
    .DATA_W   (32),
    .NUM_REGS (32),
    .ADDR_W   (5)
  ) dut (
    .clk (clk), .rst_n (rst_n), .rs (rs), .rt (rt), .rd (rd), .rd_we (rd_we),
    .i_data (i_data), .rsv_en (rsv_en), .rsv_addr (rsv_addr),
    .out_data_a (out_a), .out_data_b (out_b), .busy_a (busy_a), .busy_b (busy_b)
  );

  register_file #(
    .DATA_W   (32),
    .NUM_REGS (16),
    .ADDR_W   (5)
  ) dut16 (
    .clk (clk), .rst_n (rst_n), .rs (s_rs), .rt (s_rt), .rd (s_rd), .rd_we (s_we),
    .i_data (s_data), .rsv_en (s_rsv_en), .rsv_addr (s_rsv_addr),
    .out_data_a (s_out_a), .out_data_b (s_out_b), .busy_a (s_busy_a), .busy_b (s_busy_b)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_regs [32];
  logic        m_busy [32];
  int          n_checks = 0;
  int          n_fail   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (BYPASS && we && wa == a) return wd;
    return m_regs[a];
  endfunction

  // One clock: drive at the falling edge, queue the expected reads, update the
  // model at the rising edge, then compare just after it.
  task automatic cycle(input string tag, input logic [4:0] a, input logic [4:0] b,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rsv, input logic [4:0] ra);
    exp_t e;
    rs = a; rt = b; rd_we = we; rd = wa; i_data = wd; rsv_en = rsv; rsv_addr = ra;
    e.a = model_read(a, we, wa, wd);
    e.b = model_read(b, we, wa, wd);
    q.push_back(e);
    @(posedge clk);
    if (we && wa != 5'd0) begin
      m_regs[wa] = wd;
      m_busy[wa] = 1'b0;
    end
    if (rsv && ra != 5'd0) m_busy[ra] = 1'b1;
    #1;
    e = q.pop_front();
    check({tag, ".a"}, out_a, e.a);
    check({tag, ".b"}, out_b, e.b);
    check({tag, ".busy_a"}, {31'd0, busy_a}, {31'd0, m_busy[a]});
    check({tag, ".busy_b"}, {31'd0, busy_b}, {31'd0, m_busy[b]});
    @(negedge clk);
    rd_we = 1'b0; rsv_en = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  initial begin
    clear_model();
    rst_n = 1'b0;
    rs = '0; rt = '0; rd = '0; rd_we = 1'b0; i_data = '0; rsv_en = 1'b0; rsv_addr = '0;
    s_rs = '0; s_rt = '0; s_rd = '0; s_we = 1'b0; s_data = '0; s_rsv_en = 1'b0; s_rsv_addr = '0;
    @(negedge clk);
    check("reset.out_a", out_a, 32'h0);
    check("reset.out_b", out_b, 32'h0);
    check("reset.busy_a", {31'd0, busy_a}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    cycle("wr_r8", 5'd0, 5'd0, 1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0);
    cycle("rd_r8", 5'd8, 5'd1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

    cycle("wr_r0", 5'd0, 5'd0, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0);
    cycle("rd_r0", 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

    cycle("wr_r5", 5'd0, 5'd0, 1'b1, 5'd5, 32'h00000001, 1'b0, 5'd0);
    cycle("byp_r5", 5'd5, 5'd8, 1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0);
    cycle("after_r5", 5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

    cycle("rsv_r3", 5'd3, 5'd8, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    cycle("clr_r3", 5'd3, 5'd3, 1'b1, 5'd3, 32'h33333333, 1'b0, 5'd0);
    cycle("rsvwr_r3", 5'd3, 5'd0, 1'b1, 5'd3, 32'h44444444, 1'b1, 5'd3);
    cycle("rsv_r0", 5'd0, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    cycle("same_port", 5'd8, 5'd8, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

    for (int i = 0; i < 40; i++) begin
      cycle("rand", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end

    for (int i = 1; i < 32; i++) begin
      cycle("load", 5'(i), 5'(32 - i), 1'b1, 5'(i), 32'h01010101 * 32'(i), i == 9, 5'd9);
    end
    rs = 5'd9; rt = 5'd31; rd_we = 1'b1; rd = 5'd7; i_data = 32'hBAD0BAD0;
    #1;
    check("preRst.busy_a", {31'd0, busy_a}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst.out_a", out_a, 32'h0);
    check("rst.out_b", out_b, 32'h0);
    check("rst.busy_a", {31'd0, busy_a}, 32'h0);
    check("rst.busy_b", {31'd0, busy_b}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd_we = 1'b0;
    clear_model();
    for (int i = 0; i < 32; i++) begin
      cycle("postRst", 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    end
    cycle("postRst_wr", 5'd7, 5'd0, 1'b1, 5'd7, 32'h77777777, 1'b0, 5'd0);
    cycle("postRst_rd", 5'd7, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

    s_we = 1'b1; s_rd = 5'd4; s_data = 32'h00001111;
    @(negedge clk);
    s_rd = 5'd20; s_data = 32'h0000FFFF; s_rsv_en = 1'b1; s_rsv_addr = 5'd20;
    @(negedge clk);
    s_we = 1'b0; s_rsv_en = 1'b0; s_rs = 5'd20; s_rt = 5'd4;
    @(posedge clk);
    #1;
    check("n16.r20", s_out_a, 32'h0);
    check("n16.r4", s_out_b, 32'h00001111);
    check("n16.busy20", {31'd0, s_busy_a}, 32'h0);
    check("n16.busy4", {31'd0, s_busy_b}, 32'h0);

    if (q.size() != 0) check("queue_empty", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
